// File: rtl/gpio_port_if.sv
// CPU-side register bus of the GPIO port: one-shot request strobes answered by
// a single-cycle ready pulse that carries the read data.
interface gpio_port_if;
  // Handshake: the issuer pulses rd_en/wr_en with addr/wdata stable. The port
  // accepts only while idle and answers with ready=1 for exactly one cycle on
  // the following cycle. rdata is meaningful only while ready=1 and reads 8'h00
  // otherwise. A request seen while ready=1 is dropped, so re-strobe after ready.
  logic       rd_en;
  logic       wr_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, ready);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ready);
endinterface

// File: rtl/gpio_port.sv
// 8-bit GPIO port: DOUT/DIR registers, synchronized pin inputs, and rising-edge
// capture into a write-1-to-clear EDGE register that drives irq.
module gpio_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  gpio_port_if.slave  bus,
  input  logic [7:0]  pin_in,
  output logic [7:0]  pin_out,
  output logic [7:0]  pin_oe,
  output logic        irq,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t     state;
  logic [7:0] dout_q;
  logic [7:0] dir_q;
  logic [7:0] edge_q;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] dly_q;
  logic [7:0] pin_sync;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] rd_mux;
  logic       accept;

  assign pin_sync  = sync_q[SYNC_STAGES-1];
  assign accept    = (state == IDLE) && (bus.rd_en || bus.wr_en);
  assign pin_out   = dout_q;
  assign pin_oe    = dir_q;
  assign dbg_state = (state == RESP);

  // Pins configured as outputs never contribute edges.
  assign rise = pin_sync & ~dly_q & ~dir_q;

  always_comb begin
    clr = 8'h00;
    if (accept && bus.wr_en && (bus.addr == 2'd3)) clr = bus.wdata;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      2'd0:    rd_mux = dout_q;
      2'd1:    rd_mux = dir_q;
      2'd2:    rd_mux = pin_sync;
      default: rd_mux = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
      dly_q <= 8'h00;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= pin_sync;
    end
  end

  // A new edge beats a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= 8'h00;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~clr) | rise;
      irq    <= |edge_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus.ready <= 1'b0;
      bus.rdata <= 8'h00;
      dout_q    <= 8'h00;
      dir_q     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RESP;
            bus.ready <= 1'b1;
            // A combined read+write performs only the write.
            bus.rdata <= bus.wr_en ? 8'h00 : rd_mux;
            if (bus.wr_en) begin
              case (bus.addr)
                2'd0:    dout_q <= bus.wdata;
                2'd1:    dir_q  <= bus.wdata;
                default: ;
              endcase
            end
          end
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b0;
          bus.rdata <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: vector table of bus transactions plus
// hand-written sequences for edge capture, W1C races, ignored requests and reset.
module tb_gpio_port;

  logic       clk;
  logic       reset_n;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;
  logic       irq;
  logic       dbg_state;

  gpio_port_if bus ();

  gpio_port #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .pin_in    (pin_in),
    .pin_out   (pin_out),
    .pin_oe    (pin_oe),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       irq_at_ready;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] exp_out;
    logic [7:0] exp_oe;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction: strobe for one cycle, expect ready on the next
  // edge with the queued read value, then an idle cycle with ready/rdata low.
  task automatic do_req(input logic r, input logic w, input logic [1:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk);
    bus.rd_en = r;
    bus.wr_en = w;
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    irq_at_ready = irq;
    check($sformatf("ready_hi a%0d", a), {31'd0, bus.ready}, 32'd1);
    e = exp_q.pop_front();
    if (bus.ready) check($sformatf("rdata a%0d", a), {24'd0, bus.rdata}, {24'd0, e});
    @(posedge clk);
    #1;
    check("ready_lo", {31'd0, bus.ready}, 32'd0);
    check("rdata_idle", {24'd0, bus.rdata}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 2'd1, 8'hF0, 8'h00, 8'h00, 8'hF0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'hA5, 8'h00, 8'hA5, 8'hF0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5, 8'hF0};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h00, 8'hF0, 8'hA5, 8'hF0};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 8'h55, 8'h00, 8'hA5, 8'hF0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h00, 8'hA5, 8'hF0};
    vecs[6]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'hA5, 8'hF0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 8'h5A, 8'h00, 8'h5A, 8'hF0};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h5A, 8'h5A, 8'hF0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h5A, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00};

    reset_n   = 1'b0;
    pin_in    = 8'h00;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {31'd0, bus.ready}, 32'd0);
    check("rst rdata", {24'd0, bus.rdata}, 32'd0);
    check("rst pin_out", {24'd0, pin_out}, 32'd0);
    check("rst pin_oe", {24'd0, pin_oe}, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d pin_out", i), {24'd0, pin_out}, {24'd0, vecs[i].exp_out});
      check($sformatf("vec%0d pin_oe", i), {24'd0, pin_oe}, {24'd0, vecs[i].exp_oe});
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      do_req(1'b0, 1'b1, 2'd0, v, 8'h00);
      check("rand pin_out", {24'd0, pin_out}, {24'd0, v});
      do_req(1'b1, 1'b0, 2'd0, 8'h00, v);
    end
    do_req(1'b0, 1'b1, 2'd0, 8'h00, 8'h00);

    // Input pins: edges captured with DIR all inputs.
    @(negedge clk);
    pin_in = 8'h3C;
    repeat (3) @(posedge clk);
    do_req(1'b1, 1'b0, 2'd2, 8'h00, 8'h3C);
    check("irq after edges", {31'd0, irq_at_ready}, 32'd1);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h3C);

    // W1C partial then full clear; irq lags EDGE by a cycle.
    do_req(1'b0, 1'b1, 2'd3, 8'h0C, 8'h00);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h30);
    check("irq partial clr", {31'd0, irq}, 32'd1);
    do_req(1'b0, 1'b1, 2'd3, 8'h30, 8'h00);
    check("irq at clr ready", {31'd0, irq_at_ready}, 32'd1);
    check("irq after clr", {31'd0, irq}, 32'd0);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h00);

    // Rising edge on pin 2 lands on the same edge as a W1C of bit 2.
    @(negedge clk);
    pin_in = 8'h38;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pin_in = 8'h3C;
    @(posedge clk);
    @(posedge clk);
    do_req(1'b0, 1'b1, 2'd3, 8'h04, 8'h00);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h04);
    do_req(1'b0, 1'b1, 2'd3, 8'h04, 8'h00);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h00);

    // Output bits never capture edges.
    do_req(1'b0, 1'b1, 2'd1, 8'hFF, 8'h00);
    @(negedge clk);
    pin_in = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pin_in = 8'hFF;
    repeat (4) @(posedge clk);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
    do_req(1'b0, 1'b1, 2'd1, 8'h00, 8'h00);
    @(negedge clk);
    pin_in = 8'h3C;
    repeat (3) @(posedge clk);
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h00);

    // Requests held into the response cycle are dropped.
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.addr  = 2'd0;
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    check("b2b ready1", {31'd0, bus.ready}, 32'd1);
    check("b2b rdata", {24'd0, bus.rdata}, {24'd0, exp_q.pop_front()});
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.wdata = 8'hFF;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    check("b2b ready2", {31'd0, bus.ready}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b ready3", {31'd0, bus.ready}, 32'd0);
    check("b2b pin_out", {24'd0, pin_out}, 32'd0);
    do_req(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);

    // Set EDGE and DOUT, then reset in the middle of a response.
    @(negedge clk);
    pin_in = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pin_in = 8'h3C;
    repeat (4) @(posedge clk);
    do_req(1'b0, 1'b1, 2'd0, 8'h99, 8'h00);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.addr  = 2'd1;
    bus.wdata = 8'h0F;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    check("pre-rst ready", {31'd0, bus.ready}, 32'd1);
    check("pre-rst irq", {31'd0, irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-rst ready", {31'd0, bus.ready}, 32'd0);
    check("mid-rst rdata", {24'd0, bus.rdata}, 32'd0);
    check("mid-rst pin_out", {24'd0, pin_out}, 32'd0);
    check("mid-rst pin_oe", {24'd0, pin_oe}, 32'd0);
    check("mid-rst irq", {31'd0, irq}, 32'd0);
    check("mid-rst state", {31'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // Pins already high at release: irq rises SYNC_STAGES+2 edges later.
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-rst ready e%0d", k), {31'd0, bus.ready}, 32'd0);
      check($sformatf("post-rst irq e%0d", k), {31'd0, irq}, (k >= 4) ? 32'd1 : 32'd0);
    end
    do_req(1'b1, 1'b0, 2'd3, 8'h00, 8'h3C);

    check("queue empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
